// File: rtl/rom_burst_reader_if.sv
// Bundle of the burst-request, ROM-read and output-stream signals of rom_burst_reader.
// The reader connects through the master modport and its environment through the slave modport.
interface rom_burst_reader_if #(
    parameter int AW = 6,
    parameter int DW = 4
);
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] len;
    logic          busy;
    logic          done;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (
        input  start, start_addr, len, rom_dout, m_ready,
        output busy, done, rom_en, rom_addr, m_valid, m_data, m_last
    );

    modport slave (
        output start, start_addr, len, rom_dout, m_ready,
        input  busy, done, rom_en, rom_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/rom_burst_reader.sv
// Reads a burst of len+1 consecutive words from a synchronous ROM into a valid/ready stream.
// Reads are throttled so that buffered plus in-flight words never exceed the 2-entry FIFO.
module rom_burst_reader #(
    parameter int AW = 6,
    parameter int DW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_burst_reader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    logic [AW-1:0] base_reg;
    logic [AW-1:0] len_reg;
    logic [AW-1:0] issue_cnt_reg;
    logic          inflight_reg;
    logic          inflight_last_reg;
    logic          done_reg;

    logic [DW-1:0] fifo_data_reg [2];
    logic          fifo_last_reg [2];
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg;

    logic          issue;
    logic          issue_last;
    logic          push;
    logic          pop;
    logic          head_last;
    logic [2:0]    occupancy;

    // A read issued last cycle has its data on rom_dout now, so it is captured now.
    assign push       = inflight_reg;
    assign pop        = (count_reg != 2'd0) && bus.m_ready;
    assign head_last  = fifo_last_reg[rd_ptr_reg];
    assign issue_last = (issue_cnt_reg == len_reg);
    assign occupancy  = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (occupancy < 3'd2) begin
                    issue = 1'b1;
                    if (issue_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg          <= '0;
            len_reg           <= '0;
            issue_cnt_reg     <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && bus.start) begin
                base_reg      <= bus.start_addr;
                len_reg       <= bus.len;
                issue_cnt_reg <= '0;
            end else if (issue) begin
                issue_cnt_reg <= issue_cnt_reg + AW'(1);
            end
            inflight_reg      <= issue;
            inflight_last_reg <= issue && issue_last;
            done_reg          <= (state_reg == DRAIN) && pop && head_last;
        end
    end

    // Entries are reset as well so that m_data reads zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_last_reg[i] <= 1'b0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_reg[wr_ptr_reg] <= bus.rom_dout;
                fifo_last_reg[wr_ptr_reg] <= inflight_last_reg;
                wr_ptr_reg                <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = done_reg;
    assign bus.rom_en   = issue;
    assign bus.rom_addr = base_reg + issue_cnt_reg;
    assign bus.m_valid  = (count_reg != 2'd0);
    assign bus.m_data   = fifo_data_reg[rd_ptr_reg];
    assign bus.m_last   = (count_reg != 2'd0) && head_last;
endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader: a ROM holding mem[a] = a mod 16, a queue model of the
// expected read addresses and stream words, and one negedge compare process.
module tb_rom_burst_reader;
    localparam int AW = 6;
    localparam int DW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   pcyc   = 0;

    rom_burst_reader_if #(.AW(AW), .DW(DW)) bus ();

    rom_burst_reader #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    // Synchronous ROM: data one cycle after the enable.
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_dout <= bus.rom_addr[3:0];
    end

    // Model state
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];
    int  outstanding = 0;
    bit  done_due    = 1'b0;
    bit  model_busy  = 1'b0;
    bit  cmp_pop;
    bit  cmp_last;
    int  seen_data[$];
    int  seen_addr[$];
    int  pop_pcyc[$];
    int  first_valid_pcyc = -1;
    int  last_pop_pcyc    = -1;
    int  done_pcyc        = -1;
    bit  done_seen        = 1'b0;
    int  start_pcyc       = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_seq(input string name, input int act[$], input int req[$]);
        chk({name, "_count"}, act.size(), req.size());
        for (int i = 0; i < req.size() && i < act.size(); i++) begin
            chk($sformatf("%s[%0d]", name, i), act[i], req[i]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {bus.busy, bus.done, bus.rom_en, bus.rom_addr,
                                  bus.m_valid, bus.m_last, bus.m_data}, 0);
        end else begin
            if (done_due) model_busy = 1'b0;
            chk("done", bus.done, done_due);
            if (bus.done) begin
                done_seen = 1'b1;
                done_pcyc = pcyc;
            end
            chk("busy", bus.busy, model_busy);
            cmp_pop  = 1'b0;
            cmp_last = 1'b0;
            if (bus.m_valid) begin
                if (first_valid_pcyc < 0) first_valid_pcyc = pcyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", bus.m_valid, 0);
                end else begin
                    chk("m_data", bus.m_data, exp_q[0][DW-1:0]);
                    chk("m_last", bus.m_last, exp_q[0][DW]);
                    if (bus.m_ready) begin
                        cmp_pop  = 1'b1;
                        cmp_last = exp_q[0][DW];
                        void'(exp_q.pop_front());
                        seen_data.push_back(int'(bus.m_data));
                        pop_pcyc.push_back(pcyc);
                        if (cmp_last) last_pop_pcyc = pcyc;
                    end
                end
            end
            if (bus.rom_en) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_read", bus.rom_en, 0);
                end else begin
                    chk("rom_addr", bus.rom_addr, addr_q[0]);
                    void'(addr_q.pop_front());
                    seen_addr.push_back(int'(bus.rom_addr));
                end
                chk("outstanding_le_2", (outstanding + 1 - int'(cmp_pop)) <= 2, 1);
            end
            outstanding = outstanding + int'(bus.rom_en) - int'(cmp_pop);
            done_due    = cmp_last;
        end
    end

    // Called at posedge+1; start is visible to the following rising edge.
    task automatic begin_burst(input int sa, input int l);
        int a;
        seen_data.delete();
        seen_addr.delete();
        pop_pcyc.delete();
        first_valid_pcyc = -1;
        last_pop_pcyc    = -1;
        done_pcyc        = -1;
        done_seen        = 1'b0;
        for (int k = 0; k <= l; k++) begin
            a = (sa + k) % 64;
            addr_q.push_back(AW'(a));
            exp_q.push_back({(k == l), DW'(a % 16)});
        end
        bus.start      = 1'b1;
        bus.start_addr = AW'(sa);
        bus.len        = AW'(l);
        bus.m_ready    = 1'b1;
        @(posedge clk);
        #1;
        start_pcyc = pcyc;
        model_busy = 1'b1;
    endtask

    task automatic run_burst(input string name, input int sa, input int l,
                             input bit toggle, input int extra_start);
        begin_burst(sa, l);
        bus.start_addr = AW'(40);
        bus.len        = AW'(3);
        for (int c = 0; c < 300 && !done_seen; c++) begin
            if (c >= extra_start) bus.start = 1'b0;
            if (toggle) bus.m_ready = ~bus.m_ready;
            @(posedge clk);
            #1;
        end
        bus.start   = 1'b0;
        bus.m_ready = 1'b1;
        chk({name, "_done_seen"}, done_seen, 1);
        chk({name, "_words_left"}, exp_q.size(), 0);
        chk({name, "_reads_left"}, addr_q.size(), 0);
        chk({name, "_first_valid_latency"}, first_valid_pcyc - start_pcyc, 2);
        chk({name, "_done_after_last"}, done_pcyc - last_pop_pcyc, 1);
        $display("burst %s start_addr=%0d len=%0d words=%0d", name, sa, l, seen_data.size());
    endtask

    initial begin
        int req_d[$];
        int req_a[$];
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.len        = '0;
        bus.m_ready    = 1'b1;
        bus.rom_dout   = '0;

        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {bus.busy, bus.done, bus.rom_en, bus.rom_addr,
                                       bus.m_valid, bus.m_last, bus.m_data}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Burst A: consecutive words 5..8 with m_ready held high.
        run_burst("A", 5, 3, 1'b0, 0);
        req_d = '{5, 6, 7, 8};
        check_seq("A_data", seen_data, req_d);
        chk("A_back_to_back", pop_pcyc[pop_pcyc.size()-1] - pop_pcyc[0], 3);

        // Burst B: address wrap 63 -> 0.
        run_burst("B", 62, 4, 1'b0, 0);
        req_a = '{62, 63, 0, 1, 2};
        req_d = '{14, 15, 0, 1, 2};
        check_seq("B_addr", seen_addr, req_a);
        check_seq("B_data", seen_data, req_d);

        // Burst C: m_ready toggling each cycle.
        run_burst("C", 10, 5, 1'b1, 0);
        req_d = '{10, 11, 12, 13, 14, 15};
        check_seq("C_data", seen_data, req_d);

        // Burst D: single word, start held high while busy must be ignored.
        run_burst("D", 20, 0, 1'b0, 2);
        req_d = '{4};
        check_seq("D_data", seen_data, req_d);
        repeat (4) @(posedge clk);
        #1 chk("D_start_ignored_busy", bus.busy, 0);

        // Burst E: reset after two words of a len=7 burst.
        begin_burst(30, 7);
        bus.start = 1'b0;
        for (int c = 0; c < 50 && seen_data.size() < 2; c++) begin
            @(posedge clk);
            #1;
        end
        req_d = '{14, 15};
        check_seq("E_data_before_reset", seen_data, req_d);
        chk("E_valid_before_reset", bus.m_valid, 1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        outstanding = 0;
        done_due    = 1'b0;
        model_busy  = 1'b0;
        #1 chk("E_async_reset_outputs", {bus.busy, bus.done, bus.rom_en, bus.rom_addr,
                                         bus.m_valid, bus.m_last, bus.m_data}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        $display("reset pulse applied mid-burst and released");

        // Burst F: start presented on the first edge after reset release.
        run_burst("F", 0, 1, 1'b0, 0);
        req_d = '{0, 1};
        check_seq("F_data", seen_data, req_d);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
